// File: rtl/bp_cacc_vdp_stream.sv
// Streaming vector dot-product / sum-of-squares engine with CSR control and a single-port memory master.
// Latency: per element 5 cycles (op 0) or 3 cycles (op 1) with zero-wait memory, plus write-back and a DONE cycle.
// Backpressure: requests hold until mem_req_ready_i; at most one request outstanding; responses consumed only in WAIT states.
//
// Ports:
//   clk_i, reset_n_i                    clock, async active-low reset
//   csr_v_i/csr_w_i/csr_idx_i/csr_data_i CSR access (always accepted)
//   csr_resp_v_o/csr_resp_data_o         CSR response, one cycle after each access
//   mem_req_*                            memory request (valid/ready), store when mem_req_w_o=1
//   mem_resp_v_i/mem_resp_data_i/mem_resp_yumi_o  memory response (load data or store ack)
//   done_o                               one-cycle pulse on job completion or error
module bp_cacc_vdp_stream #(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 40,
    parameter int len_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    csr_v_i,
    input  logic                    csr_w_i,
    input  logic [2:0]              csr_idx_i,
    input  logic [63:0]             csr_data_i,
    output logic                    csr_resp_v_o,
    output logic [63:0]             csr_resp_data_o,
    output logic                    mem_req_v_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_w_o,
    output logic [addr_width_p-1:0] mem_req_addr_o,
    output logic [data_width_p-1:0] mem_req_data_o,
    input  logic                    mem_resp_v_i,
    input  logic [data_width_p-1:0] mem_resp_data_i,
    output logic                    mem_resp_yumi_o,
    output logic                    done_o
);

    localparam int elem_bytes_lp = data_width_p / 8;
    localparam int elem_shift_lp = $clog2(elem_bytes_lp);

    localparam logic [2:0] csr_a_ptr_lp   = 3'd0;
    localparam logic [2:0] csr_b_ptr_lp   = 3'd1;
    localparam logic [2:0] csr_len_lp     = 3'd2;
    localparam logic [2:0] csr_start_lp   = 3'd3;
    localparam logic [2:0] csr_status_lp  = 3'd4;
    localparam logic [2:0] csr_res_ptr_lp = 3'd5;
    localparam logic [2:0] csr_op_lp      = 3'd6;
    localparam logic [2:0] csr_result_lp  = 3'd7;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        REQ_A   = 4'd1,
        WAIT_A  = 4'd2,
        REQ_B   = 4'd3,
        WAIT_B  = 4'd4,
        MAC     = 4'd5,
        REQ_WB  = 4'd6,
        WAIT_WB = 4'd7,
        DONE    = 4'd8
    } state_e;

    state_e                  state_q,   state_d;
    logic [addr_width_p-1:0] a_ptr_q,   a_ptr_d;
    logic [addr_width_p-1:0] b_ptr_q,   b_ptr_d;
    logic [addr_width_p-1:0] res_ptr_q, res_ptr_d;
    logic [len_width_p-1:0]  len_q,     len_d;
    logic [1:0]              op_q,      op_d;
    logic [len_width_p-1:0]  idx_q,     idx_d;
    logic [data_width_p-1:0] acc_q,     acc_d;
    logic [data_width_p-1:0] a_q,       a_d;
    logic [data_width_p-1:0] b_q,       b_d;
    logic [data_width_p-1:0] result_q,  result_d;
    logic                    err_q,     err_d;
    logic                    csr_resp_v_q,    csr_resp_v_d;
    logic [63:0]             csr_resp_data_q, csr_resp_data_d;

    logic                    busy;
    logic                    cfg_wr;
    logic                    start_go;
    logic [63:0]             csr_rd_data;
    logic [addr_width_p-1:0] elem_off;
    logic [data_width_p-1:0] mac_prod;
    logic [len_width_p-1:0]  idx_inc;
    logic                    in_wait;
    logic                    unused_csr_bits;

    // Only the low bits of csr_data_i land in narrower registers.
    assign unused_csr_bits = ^csr_data_i;

    assign busy     = (state_q != IDLE);
    // Config writes are dropped while a job runs (DONE counts as busy).
    assign cfg_wr   = csr_v_i && csr_w_i && !busy;
    assign start_go = cfg_wr && (csr_idx_i == csr_start_lp) && csr_data_i[0];

    // Byte offset of the current element; wraps at the address width.
    assign elem_off = addr_width_p'(idx_q) << elem_shift_lp;
    // Sum of squares reuses A as the second operand, so B is never fetched.
    assign mac_prod = a_q * (op_q[0] ? a_q : b_q);
    assign idx_inc  = idx_q + 1'b1;
    assign in_wait  = (state_q == WAIT_A) || (state_q == WAIT_B) || (state_q == WAIT_WB);

    always_comb begin
        csr_rd_data = 64'd0;
        case (csr_idx_i)
            csr_a_ptr_lp:   csr_rd_data = 64'(a_ptr_q);
            csr_b_ptr_lp:   csr_rd_data = 64'(b_ptr_q);
            csr_len_lp:     csr_rd_data = 64'(len_q);
            csr_status_lp:  csr_rd_data = {61'd0, err_q, busy, !busy};
            csr_res_ptr_lp: csr_rd_data = 64'(res_ptr_q);
            csr_op_lp:      csr_rd_data = 64'(op_q);
            csr_result_lp:  csr_rd_data = 64'(result_q);
            default:        csr_rd_data = 64'd0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        a_ptr_d         = a_ptr_q;
        b_ptr_d         = b_ptr_q;
        res_ptr_d       = res_ptr_q;
        len_d           = len_q;
        op_d            = op_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        a_d             = a_q;
        b_d             = b_q;
        result_d        = result_q;
        err_d           = err_q;
        csr_resp_v_d    = csr_v_i;
        csr_resp_data_d = (csr_v_i && !csr_w_i) ? csr_rd_data : 64'd0;

        if (cfg_wr) begin
            case (csr_idx_i)
                csr_a_ptr_lp:   a_ptr_d   = csr_data_i[addr_width_p-1:0];
                csr_b_ptr_lp:   b_ptr_d   = csr_data_i[addr_width_p-1:0];
                csr_len_lp:     len_d     = csr_data_i[len_width_p-1:0];
                csr_res_ptr_lp: res_ptr_d = csr_data_i[addr_width_p-1:0];
                csr_op_lp:      op_d      = csr_data_i[1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    acc_d = '0;
                    idx_d = '0;
                    err_d = 1'b0;
                    if (op_q[1]) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len_q == '0) begin
                        state_d = REQ_WB;
                    end else begin
                        state_d = REQ_A;
                    end
                end
            end
            REQ_A:  if (mem_req_ready_i) state_d = WAIT_A;
            WAIT_A: begin
                if (mem_resp_v_i) begin
                    a_d     = mem_resp_data_i;
                    state_d = op_q[0] ? MAC : REQ_B;
                end
            end
            REQ_B:  if (mem_req_ready_i) state_d = WAIT_B;
            WAIT_B: begin
                if (mem_resp_v_i) begin
                    b_d     = mem_resp_data_i;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d   = acc_q + mac_prod;
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? REQ_WB : REQ_A;
            end
            REQ_WB: if (mem_req_ready_i) state_d = WAIT_WB;
            WAIT_WB: begin
                if (mem_resp_v_i) begin
                    result_d = acc_q;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= IDLE;
            a_ptr_q         <= '0;
            b_ptr_q         <= '0;
            res_ptr_q       <= '0;
            len_q           <= '0;
            op_q            <= '0;
            idx_q           <= '0;
            acc_q           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            result_q        <= '0;
            err_q           <= 1'b0;
            csr_resp_v_q    <= 1'b0;
            csr_resp_data_q <= '0;
        end else begin
            state_q         <= state_d;
            a_ptr_q         <= a_ptr_d;
            b_ptr_q         <= b_ptr_d;
            res_ptr_q       <= res_ptr_d;
            len_q           <= len_d;
            op_q            <= op_d;
            idx_q           <= idx_d;
            acc_q           <= acc_d;
            a_q             <= a_d;
            b_q             <= b_d;
            result_q        <= result_d;
            err_q           <= err_d;
            csr_resp_v_q    <= csr_resp_v_d;
            csr_resp_data_q <= csr_resp_data_d;
        end
    end

    // Memory-side outputs decode straight from the state register, so they
    // drop to zero the moment reset forces IDLE.
    assign csr_resp_v_o    = csr_resp_v_q;
    assign csr_resp_data_o = csr_resp_data_q;
    assign mem_req_v_o     = (state_q == REQ_A) || (state_q == REQ_B) || (state_q == REQ_WB);
    assign mem_req_w_o     = (state_q == REQ_WB);
    assign mem_req_addr_o  = (state_q == REQ_A)  ? (a_ptr_q + elem_off) :
                             (state_q == REQ_B)  ? (b_ptr_q + elem_off) :
                             (state_q == REQ_WB) ? res_ptr_q : '0;
    assign mem_req_data_o  = (state_q == REQ_WB) ? acc_q : '0;
    assign mem_resp_yumi_o = in_wait && mem_resp_v_i;
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_bp_cacc_vdp_stream.sv
module tb_bp_cacc_vdp_stream;

    typedef struct {
        logic        w;
        logic [39:0] addr;
        logic [63:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        csr_v, csr_w;
    logic [2:0]  csr_idx;
    logic [63:0] csr_data;
    logic        csr_resp_v_o;
    logic [63:0] csr_resp_data_o;
    logic        mem_req_v_o, mem_req_w_o, mem_resp_yumi_o, done_o;
    logic [39:0] mem_req_addr_o;
    logic [63:0] mem_req_data_o;
    logic        ready = 1'b1;
    logic        resp_v = 1'b0;
    logic        stray_v = 1'b0;
    logic [63:0] resp_data = 64'd0;

    bit          hold_ready = 1'b0;
    bit          rand_ready = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mem [logic [39:0]];
    req_t        log_q [$];
    logic [63:0] av [16];
    logic [63:0] bv [16];
    logic [63:0] last_result = 64'd0;

    always #5 clk = ~clk;

    bp_cacc_vdp_stream dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .csr_v_i         (csr_v),
        .csr_w_i         (csr_w),
        .csr_idx_i       (csr_idx),
        .csr_data_i      (csr_data),
        .csr_resp_v_o    (csr_resp_v_o),
        .csr_resp_data_o (csr_resp_data_o),
        .mem_req_v_o     (mem_req_v_o),
        .mem_req_ready_i (ready),
        .mem_req_w_o     (mem_req_w_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_resp_v_i    (resp_v | stray_v),
        .mem_resp_data_i (resp_data),
        .mem_resp_yumi_o (mem_resp_yumi_o),
        .done_o          (done_o)
    );

    // Memory model: observe handshakes mid-cycle, answer one cycle later.
    always begin : mem_model
        logic        hs, yum, w;
        logic [39:0] a;
        logic [63:0] d;
        @(negedge clk);
        hs  = mem_req_v_o && ready;
        yum = resp_v && mem_resp_yumi_o;
        w   = mem_req_w_o;
        a   = mem_req_addr_o;
        d   = mem_req_data_o;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            resp_v = 1'b0;
        end else begin
            if (yum) resp_v = 1'b0;
            if (hs) begin
                log_q.push_back('{w: w, addr: a, data: d});
                if (w) mem[a] = d;
                resp_data = w ? 64'd0 : (mem.exists(a) ? mem[a] : 64'd0);
                resp_v    = 1'b1;
            end
        end
        ready = rand_ready ? 1'($urandom_range(0, 1)) : !hold_ready;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [2:0] idx, input logic [63:0] data);
        @(posedge clk); #1;
        csr_v = 1'b1; csr_w = 1'b1; csr_idx = idx; csr_data = data;
        @(posedge clk); #1;
        csr_v = 1'b0; csr_w = 1'b0;
        chk("csr_wr_resp_v", 64'(csr_resp_v_o), 64'd1);
        chk("csr_wr_resp_data", csr_resp_data_o, 64'd0);
    endtask

    task automatic csr_read(input logic [2:0] idx, output logic [63:0] data);
        @(posedge clk); #1;
        csr_v = 1'b1; csr_w = 1'b0; csr_idx = idx; csr_data = 64'd0;
        @(posedge clk); #1;
        csr_v = 1'b0;
        chk("csr_rd_resp_v", 64'(csr_resp_v_o), 64'd1);
        data = csr_resp_data_o;
    endtask

    task automatic prog(input logic [1:0] op, input int len, input logic [39:0] ap, bp, rp);
        csr_write(3'd0, 64'(ap));
        csr_write(3'd1, 64'(bp));
        csr_write(3'd2, 64'(len));
        csr_write(3'd5, 64'(rp));
        csr_write(3'd6, 64'(op));
    endtask

    task automatic preload(input logic [1:0] op, input int len, input logic [39:0] ap, bp, rp);
        for (int i = 0; i < len; i++) begin
            mem[ap + 40'(i * 8)] = av[i];
            if (op == 2'd0) mem[bp + 40'(i * 8)] = bv[i];
        end
        mem[rp] = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc = 0; seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cyc++;
            if (done_o) begin seen = 1'b1; break; end
        end
    endtask

    // Runs a full job and checks traffic, latency, write-back, result and status
    // against a plain arithmetic model of the job.
    task automatic run_job(input string tag, input logic [1:0] op, input int len,
                           input logic [39:0] ap, bp, rp, input bit lat_chk,
                           output logic [63:0] res);
        req_t        exp_q [$];
        logic [63:0] sum, rd;
        int          exp_cyc, cyc, n;
        bit          seen;
        preload(op, len, ap, bp, rp);
        sum = 64'd0;
        if (op < 2) begin
            for (int i = 0; i < len; i++) begin
                sum += av[i] * ((op == 2'd1) ? av[i] : bv[i]);
                exp_q.push_back('{w: 1'b0, addr: ap + 40'(i * 8), data: 64'd0});
                if (op == 2'd0) exp_q.push_back('{w: 1'b0, addr: bp + 40'(i * 8), data: 64'd0});
            end
            exp_q.push_back('{w: 1'b1, addr: rp, data: sum});
        end
        exp_cyc = (op >= 2) ? 1 : ((op == 2'd0) ? 5 * len + 3 : 3 * len + 3);
        prog(op, len, ap, bp, rp);
        log_q.delete();
        csr_write(3'd3, 64'd1);
        wait_done(cyc, seen);
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            if (lat_chk) chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
            @(negedge clk);
            chk({tag, "_done_single"}, 64'(done_o), 64'd0);
        end
        chk({tag, "_nreq"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_req%0d_w", tag, i), 64'(log_q[i].w), 64'(exp_q[i].w));
            chk($sformatf("%s_req%0d_addr", tag, i), 64'(log_q[i].addr), 64'(exp_q[i].addr));
            if (exp_q[i].w) chk($sformatf("%s_req%0d_data", tag, i), log_q[i].data, exp_q[i].data);
        end
        if (op < 2) chk({tag, "_mem_store"}, mem[rp], sum);
        else        chk({tag, "_mem_untouched"}, mem[rp], 64'hDEAD_BEEF_0BAD_F00D);
        csr_read(3'd7, rd);
        res = rd;
        chk({tag, "_result"}, rd, (op < 2) ? sum : last_result);
        if (op < 2) last_result = sum;
        csr_read(3'd4, rd);
        chk({tag, "_status"}, rd, (op < 2) ? 64'd1 : 64'd5);
    endtask

    initial begin
        logic [63:0] rd, res, s_data;
        logic [39:0] s_addr, ap, bp, rp;
        int          cyc, len;
        bit          seen;
        logic [1:0]  op;

        reset_n = 1'b0; csr_v = 1'b0; csr_w = 1'b0; csr_idx = 3'd0; csr_data = 64'd0;
        #1;
        chk("rst_ctrl_outs", 64'({mem_req_v_o, mem_req_w_o, mem_resp_yumi_o, done_o, csr_resp_v_o}), 64'd0);
        chk("rst_addr", 64'(mem_req_addr_o), 64'd0);
        chk("rst_data", mem_req_data_o, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        csr_read(3'd4, rd); chk("rst_status", rd, 64'd1);
        csr_read(3'd0, rd); chk("rst_a_ptr", rd, 64'd0);
        csr_read(3'd7, rd); chk("rst_result", rd, 64'd0);

        // Stray response while idle must not be consumed.
        @(negedge clk); stray_v = 1'b1; #1;
        chk("stray_idle_yumi", 64'(mem_resp_yumi_o), 64'd0);
        @(negedge clk); stray_v = 1'b0;

        // Basic dot product 1*4+2*5+3*6.
        av[0] = 1; av[1] = 2; av[2] = 3; bv[0] = 4; bv[1] = 5; bv[2] = 6;
        run_job("dot3", 2'd0, 3, 40'h100, 40'h200, 40'h300, 1'b1, res);
        chk("dot3_is_32", res, 64'd32);

        // Empty vector: only a store of zero.
        run_job("len0", 2'd0, 0, 40'h100, 40'h200, 40'h340, 1'b1, res);
        chk("len0_is_0", res, 64'd0);

        // Sum of squares 3*3+4*4, no B loads.
        av[0] = 3; av[1] = 4;
        run_job("sq2", 2'd1, 2, 40'h400, 40'h500, 40'h600, 1'b1, res);
        chk("sq2_is_25", res, 64'd25);

        // Product wraps modulo 2^64.
        av[0] = 64'h8000_0000_0000_0000; bv[0] = 64'd2;
        run_job("wrap", 2'd0, 1, 40'h700, 40'h780, 40'h7C0, 1'b1, res);
        chk("wrap_is_0", res, 64'd0);

        // Illegal ops: error, no traffic, then a following legal job clears it.
        run_job("op3", 2'd3, 2, 40'h100, 40'h200, 40'h800, 1'b1, res);
        run_job("op2", 2'd2, 1, 40'h100, 40'h200, 40'h840, 1'b1, res);
        av[0] = 7; bv[0] = 6;
        run_job("after_err", 2'd0, 1, 40'h900, 40'hA00, 40'hB00, 1'b1, res);

        // Element addresses wrap around the top of the address space.
        for (int i = 0; i < 3; i++) begin av[i] = 64'(i + 10); bv[i] = 64'(i + 1); end
        run_job("addr_wrap", 2'd0, 3, 40'hFF_FFFF_FFF8, 40'h1000, 40'h2000, 1'b1, res);
        chk("addr_wrap_is_68", res, 64'd68);

        // Stall on REQ_B; busy-time writes are ignored.
        av[0] = 1; av[1] = 2; av[2] = 3; bv[0] = 4; bv[1] = 5; bv[2] = 6;
        preload(2'd0, 3, 40'h3000, 40'h3100, 40'h3200);
        prog(2'd0, 3, 40'h3000, 40'h3100, 40'h3200);
        log_q.delete();
        csr_write(3'd3, 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (log_q.size() >= 1) begin seen = 1'b1; break; end
        end
        chk("stall_a_hs", 64'(seen), 64'd1);
        hold_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req_v_o) break;
        end
        s_addr = mem_req_addr_o;
        s_data = mem_req_data_o;
        chk("stall_b_addr", 64'(s_addr), 64'h3100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_v_held", 64'(mem_req_v_o), 64'd1);
            chk("stall_addr_stable", 64'(mem_req_addr_o), 64'(s_addr));
            chk("stall_data_stable", mem_req_data_o, s_data);
        end
        stray_v = 1'b1; #1;
        chk("stray_reqb_yumi", 64'(mem_resp_yumi_o), 64'd0);
        @(negedge clk); stray_v = 1'b0;
        chk("stall_no_progress", 64'(log_q.size()), 64'd1);
        csr_write(3'd0, 64'h777);
        csr_write(3'd3, 64'd1);
        csr_read(3'd0, rd); chk("busy_a_ptr_kept", rd, 64'h3000);
        csr_read(3'd4, rd); chk("busy_status", rd, 64'd2);
        hold_ready = 1'b0;
        wait_done(cyc, seen);
        chk("stall_done_seen", 64'(seen), 64'd1);
        chk("stall_nreq", 64'(log_q.size()), 64'd7);
        chk("stall_store", mem[40'h3200], 64'd32);
        csr_read(3'd7, rd); chk("stall_result", rd, 64'd32);
        last_result = 64'd32;

        // Reset in WAIT_B abandons the job.
        preload(2'd0, 3, 40'h4000, 40'h4100, 40'h4200);
        prog(2'd0, 3, 40'h4000, 40'h4100, 40'h4200);
        log_q.delete();
        csr_write(3'd3, 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (log_q.size() >= 2) begin seen = 1'b1; break; end
        end
        chk("rstjob_b_hs", 64'(seen), 64'd1);
        reset_n = 1'b0; #1;
        chk("rstjob_outs", 64'({mem_req_v_o, mem_req_w_o, mem_resp_yumi_o, done_o}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstjob_no_store", 64'(log_q.size()), 64'd2);
        chk("rstjob_mem", mem[40'h4200], 64'hDEAD_BEEF_0BAD_F00D);
        csr_read(3'd4, rd); chk("rstjob_status", rd, 64'd1);
        csr_read(3'd7, rd); chk("rstjob_result_cleared", rd, 64'd0);
        last_result = 64'd0;
        run_job("rerun", 2'd0, 3, 40'h4000, 40'h4100, 40'h4200, 1'b1, res);
        chk("rerun_is_32", res, 64'd32);

        // Randomised jobs, half with random request backpressure.
        for (int j = 0; j < 8; j++) begin
            op  = 2'($urandom_range(0, 1));
            len = $urandom_range(0, 8);
            ap  = 40'h10_0000_0000 + 40'(j) * 40'h1_0000 + 40'($urandom_range(0, 255) * 8);
            bp  = ap + 40'h8000;
            rp  = ap + 40'hC000;
            for (int i = 0; i < 16; i++) begin
                av[i] = {$urandom, $urandom};
                bv[i] = {$urandom, $urandom};
            end
            rand_ready = j[0];
            run_job($sformatf("rnd%0d", j), op, len, ap, bp, rp, !j[0], res);
            rand_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
